// File: rtl/hash_op_scheduler.sv
// ============================================================================
// Module   : hash_op_scheduler
// Brief    : Round-robin front end for the cuckoo hash pipeline with a
//            same-key write scoreboard and a drain/flush sequence.
//            Optional hazard-stall statistics: define HASH_SCHED_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hash_op_scheduler #(
  parameter int KEY_WIDTH  = 2,
  parameter int DATA_WIDTH = 4,
  parameter int NUM_REQ    = 3,
  parameter int PIPE_DEPTH = 2
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NUM_REQ-1:0]                  req_valid_i,
  input  logic [NUM_REQ-1:0][1:0]             req_op_i,
  input  logic [NUM_REQ-1:0][KEY_WIDTH-1:0]   req_key_i,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  req_data_i,
  output logic [NUM_REQ-1:0]                  req_ready_o,
  input  logic                                pipe_ready_i,
  output logic                                op_valid_o,
  output logic [1:0]                          op_o,
  output logic [KEY_WIDTH-1:0]                op_key_o,
  output logic [DATA_WIDTH-1:0]               op_data_o,
  output logic [$clog2(NUM_REQ)-1:0]          op_src_o,
  input  logic                                flush_i,
  output logic                                flush_done_o,
  output logic                                err_o,
  output logic [15:0]                         hazard_stall_cnt_o
);

  localparam int SRC_W = $clog2(NUM_REQ);

  localparam logic [1:0] c_OP_LOOKUP   = 2'b00;
  localparam logic [1:0] c_OP_INSERT   = 2'b01;
  localparam logic [1:0] c_OP_DELETE   = 2'b10;
  localparam logic [1:0] c_OP_RESERVED = 2'b11;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t                               r_state;
  state_t                               w_state_nxt;
  logic [SRC_W-1:0]                     r_rr;
  logic [PIPE_DEPTH-1:0]                r_sb_valid;
  logic [PIPE_DEPTH-1:0][KEY_WIDTH-1:0] r_sb_key;

  logic                                 r_op_valid;
  logic [1:0]                           r_op;
  logic [KEY_WIDTH-1:0]                 r_op_key;
  logic [DATA_WIDTH-1:0]                r_op_data;
  logic [SRC_W-1:0]                     r_op_src;
  logic                                 r_err;

  logic [NUM_REQ-1:0]                   w_is_write;
  logic [NUM_REQ-1:0]                   w_hazard;
  logic [NUM_REQ-1:0]                   w_eligible;
  logic                                 w_issue_ok;
  logic [NUM_REQ-1:0]                   w_grant;
  logic                                 w_grant_any;
  logic [SRC_W-1:0]                     w_grant_idx;
  logic [SRC_W:0]                       w_pos;
  logic [1:0]                           w_sel_op;
  logic                                 w_issue;
  logic                                 w_sel_write;

  // Hazard check always uses the scoreboard as it stood before this edge's shift.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
    logic w_match;
    always_comb begin
      w_match = 1'b0;
      for (int j = 0; j < PIPE_DEPTH; j++) begin
        if (r_sb_valid[j] && (r_sb_key[j] == req_key_i[i])) begin
          w_match = 1'b1;
        end
      end
    end
    assign w_is_write[i] = (req_op_i[i] == c_OP_INSERT) || (req_op_i[i] == c_OP_DELETE);
    assign w_hazard[i]   = w_is_write[i] && w_match;
    assign w_eligible[i] = req_valid_i[i] && !w_hazard[i];
  end

  // Flush wins over any grant in the cycle it is seen.
  assign w_issue_ok = (r_state == ST_RUN) && pipe_ready_i && !flush_i;

  always_comb begin
    w_grant     = '0;
    w_grant_any = 1'b0;
    w_grant_idx = '0;
    w_pos       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_pos = {1'b0, r_rr} + (SRC_W + 1)'(k);
      if (w_pos >= (SRC_W + 1)'(NUM_REQ)) begin
        w_pos = w_pos - (SRC_W + 1)'(NUM_REQ);
      end
      if (!w_grant_any && w_issue_ok && w_eligible[w_pos[SRC_W-1:0]]) begin
        w_grant_any                 = 1'b1;
        w_grant[w_pos[SRC_W-1:0]]   = 1'b1;
        w_grant_idx                 = w_pos[SRC_W-1:0];
      end
    end
  end

  assign req_ready_o = w_grant;
  assign w_sel_op    = req_op_i[w_grant_idx];
  assign w_issue     = w_grant_any && (w_sel_op != c_OP_RESERVED);
  assign w_sel_write = w_issue && (w_sel_op != c_OP_LOOKUP);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN:   if (flush_i) w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (!(|r_sb_valid) && !r_op_valid) w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = flush_i ? ST_DRAIN : ST_RUN;
      default:  w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_RUN;
      r_rr       <= '0;
      r_sb_valid <= '0;
      r_sb_key   <= '0;
      r_op_valid <= 1'b0;
      r_op       <= '0;
      r_op_key   <= '0;
      r_op_data  <= '0;
      r_op_src   <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_err   <= w_grant_any && (w_sel_op == c_OP_RESERVED);
      if (w_grant_any) begin
        r_rr <= (w_grant_idx == SRC_W'(NUM_REQ - 1)) ? '0 : w_grant_idx + 1'b1;
      end
      if (pipe_ready_i) begin
        r_op_valid <= w_issue;
        if (w_issue) begin
          r_op      <= w_sel_op;
          r_op_key  <= req_key_i[w_grant_idx];
          r_op_data <= req_data_i[w_grant_idx];
          r_op_src  <= w_grant_idx;
        end
        for (int j = PIPE_DEPTH - 1; j > 0; j--) begin
          r_sb_valid[j] <= r_sb_valid[j-1];
          r_sb_key[j]   <= r_sb_key[j-1];
        end
        r_sb_valid[0] <= w_sel_write;
        r_sb_key[0]   <= req_key_i[w_grant_idx];
      end
    end
  end

  assign op_valid_o   = r_op_valid;
  assign op_o         = r_op;
  assign op_key_o     = r_op_key;
  assign op_data_o    = r_op_data;
  assign op_src_o     = r_op_src;
  assign err_o        = r_err;
  assign flush_done_o = (r_state == ST_DONE);

`ifdef HASH_SCHED_STATS_EN
  logic [15:0] r_stall_cnt;
  logic        w_stall_evt;

  assign w_stall_evt = (|(req_valid_i & w_hazard)) && pipe_ready_i && (r_state == ST_RUN);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_cnt <= '0;
    end else if (w_stall_evt && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign hazard_stall_cnt_o = r_stall_cnt;
`else
  assign hazard_stall_cnt_o = 16'd0;
`endif

endmodule

`default_nettype wire

// File: doc/hash_op_scheduler.md
# hash_op_scheduler

Front-end scheduler for the multi-table cuckoo hash pipeline. It arbitrates lookup, insert and delete requests from `NUM_REQ` requesters with round-robin fairness and issues at most one operation per pipeline advance. It keeps a write scoreboard so that two writes to the same key are never in flight together, because the forward unit resolves only one in-flight write per key. It also provides a drain/flush sequence for table maintenance.

## Interface
Parameters:
- `KEY_WIDTH`, 2: key width.
- `DATA_WIDTH`, 4: data width.
- `NUM_REQ`, 3: requester count (≥2).
- `PIPE_DEPTH`, 2: pipeline advances a write stays in flight (≥1; equals forward window).

Ports. Clock and reset: one clock; reset is asynchronous and active-low.
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-low.
- `req_valid_i` in [NUM_REQ]: request valid.
- `req_op_i` in 2 ×[NUM_REQ]: 00 lookup, 01 insert, 10 delete, 11 reserved.
- `req_key_i` in KEY_WIDTH ×[NUM_REQ]: key.
- `req_data_i` in DATA_WIDTH ×[NUM_REQ]: insert data.
- `req_ready_o` out [NUM_REQ]: grant; combinational, one-hot or zero.
- `pipe_ready_i` in 1: pipeline advance (drives the pipeline `clk_en`).
- `op_valid_o` out 1: issued operation valid.
- `op_o` out 2: issued op code.
- `op_key_o` out KEY_WIDTH: issued key.
- `op_data_o` out DATA_WIDTH: issued data.
- `op_src_o` out $clog2(NUM_REQ): granted requester index.
- `flush_i` in 1: drain request (level).
- `flush_done_o` out 1: one-cycle pulse when drained.
- `err_o` out 1: one-cycle pulse when a reserved op is consumed.
- `hazard_stall_cnt_o` out 16: see Configuration.

## Operation
- **States:**
  - RUN (reset state): normal operation.
  - DRAIN: issue is blocked.
  - DONE: one cycle only.
- **State transitions:**
  - RUN→DRAIN on `flush_i`=1. The grant in that same cycle is suppressed.
  - DRAIN→DONE when the scoreboard and output register are both empty.
  - DONE→RUN the next cycle. `flush_done_o`=1 only in DONE.
  - If `flush_i` is still high in DONE, the block re-enters DRAIN the next cycle.
- **Eligibility:** requester i is eligible when `req_valid_i[i]`=1, state is RUN, `pipe_ready_i`=1, and i is not hazard-blocked.
- **Hazard block:** an insert or delete whose key equals the key of any valid scoreboard entry. Lookups and reserved ops are never blocked.
- **Round-robin:**
  - Search starts at pointer `rr`, which resets to 0.
  - The first eligible index in the order rr, rr+1, …, wrapping modulo NUM_REQ, wins.
  - After a grant to index g, `rr`←(g+1) mod NUM_REQ. With no grant, `rr` is unchanged.
- **Output register:** loads on every cycle with `pipe_ready_i`=1.
  - With a grant: `op_valid_o`=1 plus the op fields.
  - With no grant, or a reserved op: `op_valid_o`=0.
  - A reserved op is consumed (ready=1), pulses `err_o` next cycle, and is never issued.
  - With `pipe_ready_i`=0 all op outputs hold.
- **Scoreboard:** PIPE_DEPTH entries of {valid, key}.
  - Shifts only when `pipe_ready_i`=1.
  - Entry 0 ← {granted op is insert/delete, key}.
  - The entry at index PIPE_DEPTH-1 drops out.
- **Simultaneous events:** `flush_i` has priority over any grant. Hazard comparison uses the scoreboard contents before the shift.

## Timing
- Latency: request handshake at edge n gives `op_valid_o`=1 from n+1, for one pipeline advance.
- Throughput: one op per cycle with `pipe_ready_i`=1.
- A write blocks same-key writes for exactly PIPE_DEPTH advances after its issue edge.
- Reset values:
  - `op_valid_o`, `op_o`, `op_key_o`, `op_data_o`, `op_src_o`, `flush_done_o`, `err_o` = 0.
  - `hazard_stall_cnt_o` = 0.
  - `rr`=0; scoreboard all invalid; state RUN.
- Reset asserted mid-drain returns to RUN immediately, with no `flush_done_o` pulse.
- `req_ready_o` depends on `req_valid_i`, `req_op_i`, `req_key_i`, `pipe_ready_i`, `flush_i` and registered state only. It never depends on `req_ready_o` itself.

## Configuration
- **`HASH_SCHED_STATS_EN` defined:**
  - `hazard_stall_cnt_o` increments by 1 each cycle in which at least one valid insert/delete is hazard-blocked while `pipe_ready_i`=1 and state is RUN.
  - It saturates at 16'hFFFF and resets to 0.
- **Undefined:** `hazard_stall_cnt_o` is tied to 0 and no counter logic is built. All other behaviour is identical.

## Test plan
- NUM_REQ=3, all three requesters valid with lookups, `pipe_ready_i`=1 → grants in the order 0,1,2,0,1,2. `op_src_o` follows one cycle later.
- Requester 0 inserts key 2'b01; next cycle requester 1 deletes key 2'b01 (PIPE_DEPTH=2) → requester 1 is blocked for 2 advances and granted on the 3rd cycle. With stats enabled, `hazard_stall_cnt_o`=2.
- Insert key 1 granted, then `pipe_ready_i`=0 for 5 cycles → op outputs hold, the scoreboard is frozen, and the delete of key 1 stays blocked until 2 advances after `pipe_ready_i` returns to 1.
- `flush_i`=1 while a write is in flight (PIPE_DEPTH=2) → no grants. `flush_done_o` pulses once after the scoreboard and output register empty (3 cycles), then RUN resumes.
- Requester 2 sends op 2'b11 → `req_ready_o[2]`=1, `err_o` pulses next cycle, `op_valid_o` stays 0, `rr`=0.
- `reset` asserted low during DRAIN → all outputs are 0 asynchronously. After release, the state is RUN and a fresh request is granted with a 1-cycle latency.
